wbm_cmd_bridge: RTL and testbench
=================================

// Module: wbm_cmd_bridge
// PURPOSE
//  Wishbone master stage, directly upstream of the register slaves (sys_block etc.).
//  Turns a valid/ready command stream (host/serial decoder) into single WB classic cycles,
//  returns a valid/ready response carrying read data and an error flag.
//  Holds one transaction in flight; blocks until the slave releases ack.
// PARAMETERS
//  BUS_DATA_WIDTH  32   WB data width; 8/16/32/64; BYTE_ENABLES = BUS_DATA_WIDTH/8
//  BUS_ADDR_WIDTH  8    WB address width
//  TIMEOUT_CYCLES  255  cycles to wait for ack/err, and for ack release; 1..65535; 16-bit counter
// PORTS
//  wb_clk_i      in   1     clock, rising edge
//  wb_rst_n_i    in   1     reset, asynchronous, active-low
//  cmd_valid_i   in   1     command present
//  cmd_ready_o   out  1     bridge accepts command (registered)
//  cmd_we_i      in   1     1=write, 0=read
//  cmd_sel_i     in   BE    byte enables
//  cmd_adr_i     in   AW    address
//  cmd_dat_i     in   DW    write data
//  rsp_valid_o   out  1     response present
//  rsp_ready_i   in   1     consumer takes response
//  rsp_dat_o     out  DW    read data; 0 for writes and errors
//  rsp_err_o     out  1     wbm_err_i seen, or timeout
//  wbm_cyc_o     out  1     WB cycle
//  wbm_stb_o     out  1     WB strobe; always equal to wbm_cyc_o
//  wbm_we_o      out  1     WB write enable
//  wbm_sel_o     out  BE    WB byte selects
//  wbm_adr_o     out  AW    WB address
//  wbm_dat_o     out  DW    WB write data
//  wbm_dat_i     in   DW    WB read data
//  wbm_ack_i     in   1     WB ack
//  wbm_err_i     in   1     WB error
// BEHAVIOUR
//  - Reset (async assert, sync-to-clock deassert irrelevant): all outputs 0, state IDLE.
//    cmd_ready_o goes 1 on first edge after release. Reset mid-cycle drops cyc/stb at once.
//  - FSM: IDLE -> BUS -> RELEASE -> RESP -> IDLE. All outputs registered.
//  - IDLE: cmd_ready_o=1. On edge with cmd_valid_i & cmd_ready_o:
//      latch we/sel/adr/dat onto wbm_*; cyc=stb=1; ready=0; clear timer; -> BUS.
//  - BUS: sample wbm_ack_i/wbm_err_i each edge.
//      ack & !err: rsp_dat <= read ? wbm_dat_i : 0; rsp_err <= 0.
//      err (with or without ack): rsp_dat <= 0; rsp_err <= 1.
//      On either, drop cyc/stb the same edge -> RELEASE.
//  - RELEASE: slaves hold ack until stb falls. Wait for wbm_ack_i==0 before responding, so a
//    stale ack is never taken as the next cycle's ack. Then rsp_valid <= 1 -> RESP.
//  - RESP: rsp_valid/dat/err held stable until rsp_ready_i. On that edge rsp_valid <= 0,
//    cmd_ready_o <= 1 -> IDLE. No new command accepted before the response is taken.
//  - Latency vs a 1-cycle-ack slave: accept at edge 0; cyc/stb high edges 1..2;
//    ack seen edge 2; ack low seen edge 4; rsp_valid high after edge 4.
//  - wbm_we/sel/adr/dat hold their value after cyc drops until the next accept.
// CONFIGURATION
//  WBM_BRIDGE_TIMEOUT_EN defined:
//    16-bit counter, cleared on accept and on entry to RELEASE, increments in BUS/RELEASE.
//    BUS reaching TIMEOUT_CYCLES with no ack/err: drop cyc/stb, rsp_err=1, rsp_dat=0 -> RELEASE.
//    RELEASE reaching TIMEOUT_CYCLES with ack still high: force rsp_err=1 -> RESP.
//  Undefined: no counter; BUS and RELEASE wait indefinitely.
// TESTING
//  1 reset: hold wb_rst_n_i=0 mid-BUS -> cyc/stb/rsp_valid/cmd_ready 0 immediately;
//    cmd_ready=1 one edge after release.
//  2 write adr 8'h04, dat 32'hA5A5_1234, sel 4'hF to sys_block, then read 8'h04
//    -> rsp_err=0, rsp_dat=32'hA5A5_1234; rsp_valid 4 edges after accept.
//  3 write sel 4'b0010, dat 32'h0000_FF00 over 32'hA5A5_1234 -> read back 32'hA5A5_FF34.
//  4 slave asserts ack and err together on a read -> rsp_err=1, rsp_dat=0; single response.
//  5 rsp_ready_i low 10 cycles; cmd_valid_i held high -> rsp fields stable, cmd_ready=0;
//    next cmd accepted edge after rsp_ready.
//  6 TIMEOUT_EN, TIMEOUT_CYCLES=16, unmapped adr (no ack)
//    -> cyc drops after 16 BUS cycles; rsp_err=1, rsp_dat=0.

Source files
------------

// File: rtl/wbm_cmd_bridge_if.sv
// rtl/wbm_cmd_bridge_if.sv - command/response stream and Wishbone master signal bundle
interface wbm_cmd_bridge_if #(
    parameter int DW = 32,
    parameter int AW = 8
);
    localparam int BE = DW / 8;

    // command stream from the host/serial decoder
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_we_i;
    logic [BE-1:0] cmd_sel_i;
    logic [AW-1:0] cmd_adr_i;
    logic [DW-1:0] cmd_dat_i;

    // response stream back to the host
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_dat_o;
    logic          rsp_err_o;

    // Wishbone classic master side
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [BE-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i;
    logic          wbm_ack_i;
    logic          wbm_err_i;

    // the bridge itself
    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
        input  rsp_ready_i,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );

    // everything around the bridge: command source, response sink and WB slave
    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i,
        output rsp_ready_i,
        output wbm_dat_i, wbm_ack_i, wbm_err_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
    );
endinterface

// File: rtl/wbm_cmd_bridge.sv
// rtl/wbm_cmd_bridge.sv - command stream to single Wishbone classic cycle bridge (optional WBM_BRIDGE_TIMEOUT_EN)
module wbm_cmd_bridge #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    wbm_cmd_bridge_if.master     bus
);
    localparam int DW = BUS_DATA_WIDTH;
    localparam int AW = BUS_ADDR_WIDTH;
    localparam int BE = BUS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUS     = 2'd1,
        S_RELEASE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t        r_state,     w_state_nxt;
    logic          r_cmd_ready, w_cmd_ready_nxt;
    logic          r_cyc,       w_cyc_nxt;
    logic          r_we,        w_we_nxt;
    logic [BE-1:0] r_sel,       w_sel_nxt;
    logic [AW-1:0] r_adr,       w_adr_nxt;
    logic [DW-1:0] r_wdat,      w_wdat_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0] r_rsp_dat,   w_rsp_dat_nxt;
    logic          r_rsp_err,   w_rsp_err_nxt;
    logic          w_timer_hit;

`ifdef WBM_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_timer, w_timer_nxt;

    // hit on the edge that completes TIMEOUT_CYCLES waiting cycles in the current state
    assign w_timer_hit = (r_timer == TO_LAST);

    // timer restarts on every state change (accept, entry to RELEASE) and counts while waiting
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_state_nxt != r_state) begin
            w_timer_nxt = 16'd0;
        end else if (r_state == S_BUS || r_state == S_RELEASE) begin
            w_timer_nxt = r_timer + 16'd1;
        end
    end

    // timer register
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_timer <= 16'd0;
        end else begin
            r_timer <= w_timer_nxt;
        end
    end
`else
    assign w_timer_hit = 1'b0;
`endif

    // next state and next value of every registered output
    always_comb begin
        w_state_nxt     = r_state;
        w_cmd_ready_nxt = r_cmd_ready;
        w_cyc_nxt       = r_cyc;
        w_we_nxt        = r_we;
        w_sel_nxt       = r_sel;
        w_adr_nxt       = r_adr;
        w_wdat_nxt      = r_wdat;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_dat_nxt   = r_rsp_dat;
        w_rsp_err_nxt   = r_rsp_err;

        case (r_state)
            S_IDLE: begin
                w_cmd_ready_nxt = 1'b1;
                if (bus.cmd_valid_i && r_cmd_ready) begin
                    w_we_nxt        = bus.cmd_we_i;
                    w_sel_nxt       = bus.cmd_sel_i;
                    w_adr_nxt       = bus.cmd_adr_i;
                    w_wdat_nxt      = bus.cmd_dat_i;
                    w_cyc_nxt       = 1'b1;
                    w_cmd_ready_nxt = 1'b0;
                    w_state_nxt     = S_BUS;
                end
            end
            S_BUS: begin
                // err wins over a simultaneous ack; a silent slave ends via the timer
                if (bus.wbm_err_i) begin
                    w_rsp_dat_nxt = '0;
                    w_rsp_err_nxt = 1'b1;
                    w_cyc_nxt     = 1'b0;
                    w_state_nxt   = S_RELEASE;
                end else if (bus.wbm_ack_i) begin
                    w_rsp_dat_nxt = r_we ? '0 : bus.wbm_dat_i;
                    w_rsp_err_nxt = 1'b0;
                    w_cyc_nxt     = 1'b0;
                    w_state_nxt   = S_RELEASE;
                end else if (w_timer_hit) begin
                    w_rsp_dat_nxt = '0;
                    w_rsp_err_nxt = 1'b1;
                    w_cyc_nxt     = 1'b0;
                    w_state_nxt   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // respond only once the slave has dropped ack, so it cannot leak into the next cycle
                if (!bus.wbm_ack_i) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end else if (w_timer_hit) begin
                    w_rsp_dat_nxt   = '0;
                    w_rsp_err_nxt   = 1'b1;
                    w_rsp_valid_nxt = 1'b1;
                    w_state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready_i) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_cmd_ready_nxt = 1'b1;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // state and output registers; reset drops cyc/stb immediately
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_wdat      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_cyc       <= w_cyc_nxt;
            r_we        <= w_we_nxt;
            r_sel       <= w_sel_nxt;
            r_adr       <= w_adr_nxt;
            r_wdat      <= w_wdat_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_dat   <= w_rsp_dat_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    assign bus.cmd_ready_o = r_cmd_ready;
    assign bus.wbm_cyc_o   = r_cyc;
    assign bus.wbm_stb_o   = r_cyc;
    assign bus.wbm_we_o    = r_we;
    assign bus.wbm_sel_o   = r_sel;
    assign bus.wbm_adr_o   = r_adr;
    assign bus.wbm_dat_o   = r_wdat;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_dat_o   = r_rsp_dat;
    assign bus.rsp_err_o   = r_rsp_err;
endmodule

// File: tb/tb_wbm_cmd_bridge.sv
// tb/tb_wbm_cmd_bridge.sv - directed self-checking bench for wbm_cmd_bridge with a sys_block-like slave
module tb_wbm_cmd_bridge;
    logic clk = 1'b0;
    logic rst_n;
    logic force_err;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wbm_cmd_bridge_if #(.DW(32), .AW(8)) bus ();

    wbm_cmd_bridge #(
        .BUS_DATA_WIDTH(32),
        .BUS_ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus.master)
    );

    // slave: 16 words at 0x00..0x3F, acks while stb is high, nothing above 0x3F answers
    logic        s_ack, s_err;
    logic [31:0] mem [0:15];
    logic        mapped;
    logic [3:0]  idx;

    assign mapped        = (bus.wbm_adr_o < 8'h40);
    assign idx           = bus.wbm_adr_o[5:2];
    assign bus.wbm_ack_i = s_ack;
    assign bus.wbm_err_i = s_err;
    assign bus.wbm_dat_i = mapped ? mem[idx] : 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
        end else if (bus.wbm_cyc_o && bus.wbm_stb_o && mapped) begin
            s_ack <= 1'b1;
            s_err <= force_err;
            if (!s_ack && bus.wbm_we_o && !force_err)
                for (int b = 0; b < 4; b++)
                    if (bus.wbm_sel_o[b]) mem[idx][8*b +: 8] <= bus.wbm_dat_o[8*b +: 8];
        end else begin
            s_ack <= 1'b0;
            s_err <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int guard = 0;
        while (!bus.cmd_ready_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("accept_wait", bus.cmd_ready_o, 1);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            lat = k;
            if (bus.rsp_valid_o) break;
        end
        if (!bus.rsp_valid_o) check("rsp_wait", bus.rsp_valid_o, 1);
    endtask

    task automatic take_rsp();
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [3:0] sel, input logic [7:0] adr,
                       input logic [31:0] dat, output logic [31:0] rdat,
                       output logic rerr, output int lat);
        bus.cmd_we_i    = we;
        bus.cmd_sel_i   = sel;
        bus.cmd_adr_i   = adr;
        bus.cmd_dat_i   = dat;
        bus.cmd_valid_i = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        wait_rsp(lat);
        rdat = bus.rsp_dat_o;
        rerr = bus.rsp_err_o;
        take_rsp();
    endtask

    logic [31:0] rd, saved_dat;
    logic        re, saved_err, stable;
    int          lat;

    initial begin
        rst_n           = 1'b0;
        force_err       = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_sel_i   = 4'h0;
        bus.cmd_adr_i   = 8'h0;
        bus.cmd_dat_i   = 32'h0;
        bus.rsp_ready_i = 1'b0;

        // reset state and first ready
        repeat (3) @(posedge clk);
        #1;
        check("rst_cyc",       bus.wbm_cyc_o,   0);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_ready",     bus.cmd_ready_o, 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", bus.cmd_ready_o, 0);
        @(posedge clk); #1;
        check("ready_after_edge", bus.cmd_ready_o, 1);

        // reset in the middle of a bus cycle to an unmapped address
        bus.cmd_we_i    = 1'b0;
        bus.cmd_sel_i   = 4'hF;
        bus.cmd_adr_i   = 8'hF0;
        bus.cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        check("mid_cyc_up", bus.wbm_cyc_o, 1);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cyc",   bus.wbm_cyc_o,   0);
        check("mid_rst_stb",   bus.wbm_stb_o,   0);
        check("mid_rst_valid", bus.rsp_valid_o, 0);
        check("mid_rst_ready", bus.cmd_ready_o, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", bus.cmd_ready_o, 1);

        // full write then read-back with 1-cycle-ack latency
        txn(1'b1, 4'hF, 8'h04, 32'hA5A5_1234, rd, re, lat);
        check("wr_lat", lat, 4);
        check("wr_err", re, 0);
        check("wr_dat", rd, 0);
        check("wr_valid_dropped", bus.rsp_valid_o, 0);
        check("wr_ready_back", bus.cmd_ready_o, 1);
        txn(1'b0, 4'hF, 8'h04, 32'h0, rd, re, lat);
        check("rd_lat", lat, 4);
        check("rd_err", re, 0);
        check("rd_dat", rd, 32'hA5A5_1234);
        check("adr_held", bus.wbm_adr_o, 8'h04);
        check("we_held", bus.wbm_we_o, 0);

        // partial byte write
        txn(1'b1, 4'b0010, 8'h04, 32'h0000_FF00, rd, re, lat);
        check("pw_err", re, 0);
        txn(1'b0, 4'hF, 8'h04, 32'h0, rd, re, lat);
        check("pw_rd_dat", rd, 32'hA5A5_FF34);

        // ack and err together on a read
        force_err = 1'b1;
        txn(1'b0, 4'hF, 8'h04, 32'h0, rd, re, lat);
        force_err = 1'b0;
        check("ackerr_err", re, 1);
        check("ackerr_dat", rd, 0);
        check("ackerr_lat", lat, 4);
        stable = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.rsp_valid_o || bus.wbm_cyc_o) stable = 1'b0;
        end
        check("ackerr_single", stable, 1);

        // response back-pressure with the next command already waiting
        bus.cmd_we_i    = 1'b0;
        bus.cmd_sel_i   = 4'hF;
        bus.cmd_adr_i   = 8'h04;
        bus.cmd_valid_i = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        bus.cmd_adr_i = 8'h08;
        wait_rsp(lat);
        saved_dat = bus.rsp_dat_o;
        saved_err = bus.rsp_err_o;
        check("bp_first_dat", saved_dat, 32'hA5A5_FF34);
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (!bus.rsp_valid_o || bus.rsp_dat_o !== saved_dat || bus.rsp_err_o !== saved_err ||
                bus.cmd_ready_o || bus.wbm_cyc_o) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        take_rsp();
        check("bp_valid_dropped", bus.rsp_valid_o, 0);
        check("bp_ready_up", bus.cmd_ready_o, 1);
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        check("bp_next_accept", bus.wbm_cyc_o, 1);
        check("bp_next_adr", bus.wbm_adr_o, 8'h08);
        wait_rsp(lat);
        check("bp_next_dat", bus.rsp_dat_o, 0);
        check("bp_next_lat", lat, 4);
        take_rsp();

`ifdef WBM_BRIDGE_TIMEOUT_EN
        // unmapped address: timeout after 16 bus cycles, one more edge to see ack low
        txn(1'b0, 4'hF, 8'hF0, 32'h0, rd, re, lat);
        check("to_lat", lat, 17);
        check("to_err", re, 1);
        check("to_dat", rd, 0);
        check("to_cyc_low", bus.wbm_cyc_o, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
